// File: rtl/poci_tx.sv
// poci_tx: controller-in serial transmitter, MSB-first on sclk falls with auto-incrementing read address; POCI_PARITY_EN appends an odd parity bit.
module poci_tx #(
  parameter int TIMEOUT_CYCLES = 7,
  parameter int CNT_W = 16
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       addr_load,
  input  logic [7:0] addr_in,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       serial_out,
  output logic       busy,
  output logic       byte_done,
  output logic       timeout
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, SHIFT = 2'd2;
`ifdef POCI_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
  logic par;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif
  logic [1:0] state;
  logic s1, s2, s3;
  logic [7:0] shreg;
  logic [3:0] bitcnt;
  logic [CNT_W-1:0] idle_cnt;
  logic rise, fall, expire;
  logic [CNT_W-1:0] idle_inc;
  always_comb begin
    rise = s2 & ~s3;
    fall = ~s2 & s3;
    expire = idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    idle_inc = (&idle_cnt) ? idle_cnt : idle_cnt + 1'b1;
    busy = state != IDLE;
  end
  always_ff @(posedge iclk) begin
    if (rst) begin
      {s1, s2, s3} <= 3'b000;
      state <= IDLE;
      rd_addr <= 8'h00;
      serial_out <= 1'b0;
      byte_done <= 1'b0;
      timeout <= 1'b0;
      shreg <= 8'h00;
      bitcnt <= 4'd0;
      idle_cnt <= '0;
`ifdef POCI_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      {s1, s2, s3} <= {sclk, s1, s2};
      byte_done <= 1'b0;
      timeout <= 1'b0;
      if (addr_load) begin
        rd_addr <= addr_in;
        state <= FETCH;
        idle_cnt <= '0;
      end else if (state == IDLE) begin
        serial_out <= 1'b0;
        idle_cnt <= '0;
      end else if (state == FETCH) begin
        shreg <= rd_data;
        serial_out <= rd_data[7];
        bitcnt <= 4'd0;
        state <= SHIFT;
        idle_cnt <= (rise | fall) ? '0 : idle_inc;
`ifdef POCI_PARITY_EN
        par <= ~^rd_data;
`endif
      end else if (rise | fall) begin
        idle_cnt <= '0;
        if (fall && bitcnt == LAST) begin
          byte_done <= 1'b1;
          rd_addr <= rd_addr + 8'h01;
          state <= FETCH;
        end else if (fall) begin
          shreg <= shreg << 1;
`ifdef POCI_PARITY_EN
          serial_out <= (bitcnt == 4'd7) ? par : shreg[6];
`else
          serial_out <= shreg[6];
`endif
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (expire) begin
        timeout <= 1'b1;
        serial_out <= 1'b0;
        state <= IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_inc;
      end
    end
  end
endmodule
